// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl shared definitions
// register map, bus widths, pin limits
package gpio_ctrl_pkg;

  localparam int GPIO_DW       = 32;
  localparam int GPIO_AW       = 3;
  localparam int GPIO_MAX_PINS = 32;
  localparam int GPIO_NR_REGS  = 8;

  typedef logic [GPIO_AW-1:0] gpio_addr_t;
  typedef logic [GPIO_DW-1:0] gpio_word_t;

  localparam gpio_addr_t GPIO_REG_DATA_OUT = 3'd0;
  localparam gpio_addr_t GPIO_REG_DO_SET   = 3'd1;
  localparam gpio_addr_t GPIO_REG_DO_CLR   = 3'd2;
  localparam gpio_addr_t GPIO_REG_OE       = 3'd3;
  localparam gpio_addr_t GPIO_REG_DATA_IN  = 3'd4;
  localparam gpio_addr_t GPIO_REG_RISE_EN  = 3'd5;
  localparam gpio_addr_t GPIO_REG_FALL_EN  = 3'd6;
  localparam gpio_addr_t GPIO_REG_STATUS   = 3'd7;

  // one-hot register select for a word index
  function automatic logic [GPIO_NR_REGS-1:0] gpio_sel(
    input gpio_addr_t a
  );
    logic [GPIO_NR_REGS-1:0] s;
    s    = '0;
    s[a] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/gpio_ctrl_if.sv
// gpio_ctrl register bus
// single-cycle request, registered read response
interface gpio_ctrl_if;
  import gpio_ctrl_pkg::*;

  logic       req_valid;
  logic       req_wr;
  gpio_addr_t req_addr;
  gpio_word_t req_wdata;
  logic       rsp_valid;
  gpio_word_t rsp_rdata;

  modport master (
    output req_valid,
    output req_wr,
    output req_addr,
    output req_wdata,
    input  rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_wr,
    input  req_addr,
    input  req_wdata,
    output rsp_valid,
    output rsp_rdata
  );

endinterface

// File: rtl/gpio_ctrl_sync.sv
// gpio_sync: multi-flop pad input synchroniser
// chain clears to zero on reset
module gpio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  // shift raw pad values through the chain
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO block
// out/oe regs, input sync, sticky edge irq
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int NR_GPIOS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  gpio_ctrl_if.slave          bus,
  output logic [NR_GPIOS-1:0] gpio_oe,
  output logic [NR_GPIOS-1:0] gpio_do,
  input  logic [NR_GPIOS-1:0] gpio_di,
  output logic                irq
);

  localparam int N = NR_GPIOS;
  localparam logic [2:0] ARM_DONE =
    3'(SYNC_STAGES + 1);

  typedef logic [N-1:0] pins_t;

  pins_t sync;
  pins_t prev;
  pins_t rise_en;
  pins_t fall_en;
  pins_t status;
  pins_t rise;
  pins_t fall;
  pins_t wdata;
  pins_t w1c;
  pins_t rd_pins;

  logic [GPIO_NR_REGS-1:0] sel;
  gpio_word_t rd_word;
  logic [2:0] arm_cnt;
  logic       armed;
  logic       wr_en;
  logic       rd_en;
  logic       unused_wdata;

  gpio_sync #(
    .WIDTH  (N),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (gpio_di),
    .q     (sync)
  );

  assign wr_en = bus.req_valid & bus.req_wr;
  assign rd_en = bus.req_valid & ~bus.req_wr;
  assign sel   = gpio_sel(bus.req_addr);
  assign wdata = bus.req_wdata[N-1:0];

  // bits above the pin count are dropped
  assign unused_wdata = ^bus.req_wdata;

  // edges are ignored until the sync chain
  // and prev hold post-reset pad values
  assign armed = (arm_cnt == ARM_DONE);

  assign w1c =
    (wr_en & sel[GPIO_REG_STATUS]) ?
    wdata : '0;

  assign rise =
    sync & ~prev & rise_en & {N{armed}};
  assign fall =
    ~sync & prev & fall_en & {N{armed}};

  // read data selection, zero-extended
  always_comb begin
    rd_pins = '0;
    unique case (1'b1)
      sel[GPIO_REG_DATA_OUT],
      sel[GPIO_REG_DO_SET],
      sel[GPIO_REG_DO_CLR]:
        rd_pins = gpio_do;
      sel[GPIO_REG_OE]:
        rd_pins = gpio_oe;
      sel[GPIO_REG_DATA_IN]:
        rd_pins = sync;
      sel[GPIO_REG_RISE_EN]:
        rd_pins = rise_en;
      sel[GPIO_REG_FALL_EN]:
        rd_pins = fall_en;
      sel[GPIO_REG_STATUS]:
        rd_pins = status;
      default:
        rd_pins = '0;
    endcase
    rd_word        = '0;
    rd_word[N-1:0] = rd_pins;
  end

  // software-writable control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_do <= '0;
      gpio_oe <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else if (wr_en) begin
      unique case (1'b1)
        sel[GPIO_REG_DATA_OUT]:
          gpio_do <= wdata;
        sel[GPIO_REG_DO_SET]:
          gpio_do <= gpio_do | wdata;
        sel[GPIO_REG_DO_CLR]:
          gpio_do <= gpio_do & ~wdata;
        sel[GPIO_REG_OE]:
          gpio_oe <= wdata;
        sel[GPIO_REG_RISE_EN]:
          rise_en <= wdata;
        sel[GPIO_REG_FALL_EN]:
          fall_en <= wdata;
        default: begin
        end
      endcase
    end
  end

  // registered read response
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= rd_en;
      if (rd_en) begin
        bus.rsp_rdata <= rd_word;
      end
    end
  end

  // edge capture, sticky status, irq, arming
  always_ff @(posedge clk) begin
    if (reset) begin
      prev    <= '0;
      status  <= '0;
      irq     <= 1'b0;
      arm_cnt <= '0;
    end else begin
      prev    <= sync;
      status  <= (status & ~w1c) | rise | fall;
      irq     <= |status;
      if (!armed) begin
        arm_cnt <= arm_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: two instances (8/2 and 32/3)
// against a pad-history reference model
module tb_gpio_ctrl;
  import gpio_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  gpio_ctrl_if bus0();
  gpio_ctrl_if bus1();

  logic [7:0]  oe0, do0, pad0;
  logic [31:0] oe1, do1, pad1;
  logic        irq0, irq1;

  logic [1:0]       rv, rwr;
  logic [1:0][2:0]  ra;
  logic [1:0][31:0] rdat;

  assign bus0.req_valid = rv[0];
  assign bus0.req_wr    = rwr[0];
  assign bus0.req_addr  = ra[0];
  assign bus0.req_wdata = rdat[0];
  assign bus1.req_valid = rv[1];
  assign bus1.req_wr    = rwr[1];
  assign bus1.req_addr  = ra[1];
  assign bus1.req_wdata = rdat[1];

  gpio_ctrl #(
    .NR_GPIOS    (8),
    .SYNC_STAGES (2)
  ) dut0 (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus0),
    .gpio_oe (oe0),
    .gpio_do (do0),
    .gpio_di (pad0),
    .irq     (irq0)
  );

  gpio_ctrl #(
    .NR_GPIOS    (32),
    .SYNC_STAGES (3)
  ) dut1 (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus1),
    .gpio_oe (oe1),
    .gpio_do (do1),
    .gpio_di (pad1),
    .irq     (irq1)
  );

  logic [1:0][31:0] d_oe, d_do, d_rd;
  logic [1:0]       d_irq, d_rv;

  assign d_oe[0]  = {24'b0, oe0};
  assign d_oe[1]  = oe1;
  assign d_do[0]  = {24'b0, do0};
  assign d_do[1]  = do1;
  assign d_rd[0]  = bus0.rsp_rdata;
  assign d_rd[1]  = bus1.rsp_rdata;
  assign d_irq[0] = irq0;
  assign d_irq[1] = irq1;
  assign d_rv[0]  = bus0.rsp_valid;
  assign d_rv[1]  = bus1.rsp_valid;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h",
               nm, k, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] mask_of(input int k);
    return (k == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  function automatic int stages_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  logic [1:0][31:0] m_do, m_oe, m_re, m_fe, m_st, m_rd;
  logic [1:0]       m_irq, m_rv;
  logic [31:0]      hist [2][5];
  int               m_cyc [2];
  bit               started = 1'b0;

  // hist[k][i] = pad value captured i+1 edges ago
  always @(posedge clk) begin
    logic [31:0] pad, sy, pv, ev, w, rdv, mk;
    int          s;
    logic        wr;
    for (int k = 0; k < 2; k++) begin
      mk  = mask_of(k);
      s   = stages_of(k);
      pad = (k == 0) ? {24'b0, pad0} : pad1;
      if (reset) begin
        m_do[k] = '0; m_oe[k] = '0;
        m_re[k] = '0; m_fe[k] = '0;
        m_st[k] = '0; m_rd[k] = '0;
        m_irq[k] = 1'b0; m_rv[k] = 1'b0;
        for (int i = 0; i < 5; i++) hist[k][i] = '0;
        m_cyc[k] = 0;
      end else begin
        sy = hist[k][s-1];
        pv = hist[k][s];
        w  = rdat[k] & mk;
        case (ra[k])
          3'd0, 3'd1, 3'd2: rdv = m_do[k];
          3'd3:             rdv = m_oe[k];
          3'd4:             rdv = sy;
          3'd5:             rdv = m_re[k];
          3'd6:             rdv = m_fe[k];
          default:          rdv = m_st[k];
        endcase
        ev = '0;
        if (m_cyc[k] > s)
          ev = ((sy & ~pv & m_re[k]) |
                (~sy & pv & m_fe[k])) & mk;
        wr = rv[k] & rwr[k];
        m_irq[k] = |m_st[k];
        m_rv[k]  = rv[k] & ~rwr[k];
        if (m_rv[k]) m_rd[k] = rdv;
        m_st[k] = (m_st[k] &
                   ~((wr && ra[k] == 3'd7) ? w : 32'h0))
                  | ev;
        if (wr) begin
          case (ra[k])
            3'd0: m_do[k] = w;
            3'd1: m_do[k] = m_do[k] | w;
            3'd2: m_do[k] = m_do[k] & ~w;
            3'd3: m_oe[k] = w;
            3'd5: m_re[k] = w;
            3'd6: m_fe[k] = w;
            default: ;
          endcase
        end
        for (int i = 4; i > 0; i--) hist[k][i] = hist[k][i-1];
        hist[k][0] = pad & mk;
        if (m_cyc[k] < 1000) m_cyc[k]++;
      end
    end
    if (reset) started = 1'b1;
  end

  // every-cycle comparison of all outputs
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk("cyc_oe", k, d_oe[k], m_oe[k]);
        chk("cyc_do", k, d_do[k], m_do[k]);
        chk("cyc_irq", k, {31'b0, d_irq[k]},
            {31'b0, m_irq[k]});
        chk("cyc_rsp_valid", k, {31'b0, d_rv[k]},
            {31'b0, m_rv[k]});
        if (m_rv[k])
          chk("cyc_rdata", k, d_rd[k], m_rd[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int k, input logic [2:0] a,
                    input logic [31:0] d);
    rv[k] = 1'b1; rwr[k] = 1'b1; ra[k] = a; rdat[k] = d;
    tick();
    rv[k] = 1'b0; rwr[k] = 1'b0;
  endtask

  task automatic rd(input int k, input logic [2:0] a,
                    input logic [31:0] e, input string nm);
    rv[k] = 1'b1; rwr[k] = 1'b0; ra[k] = a;
    tick();
    rv[k] = 1'b0;
    chk({nm, "_vld"}, k, {31'b0, d_rv[k]}, 32'h1);
    chk(nm, k, d_rd[k], e);
  endtask

  initial begin
    rv = '0; rwr = '0; ra = '0; rdat = '0;
    pad0 = 8'hFF; pad1 = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // rise_en enabled right after reset, pins high
    wr(0, GPIO_REG_RISE_EN, 32'hFF);
    chk("rst_oe", 0, d_oe[0], 32'h0);
    chk("rst_irq", 0, {31'b0, irq0}, 32'h0);
    rd(0, 3'd0, 32'h0,  "rst_do");
    rd(0, 3'd1, 32'h0,  "rst_set");
    rd(0, 3'd2, 32'h0,  "rst_clr");
    rd(0, 3'd3, 32'h0,  "rst_oe_rd");
    rd(0, 3'd4, 32'hFF, "rst_din");
    rd(0, 3'd5, 32'hFF, "rst_re");
    rd(0, 3'd6, 32'h0,  "rst_fe");
    rd(0, 3'd7, 32'h0,  "arm_status");
    chk("arm_irq", 0, {31'b0, irq0}, 32'h0);
    rd(1, 3'd4, 32'h0,  "rst_din");
    wr(0, GPIO_REG_RISE_EN, 32'h0);

    // output / direction registers
    wr(0, GPIO_REG_OE, 32'h0F);
    chk("oe_0f", 0, d_oe[0], 32'h0F);
    wr(0, GPIO_REG_DATA_OUT, 32'hA5);
    chk("do_a5", 0, d_do[0], 32'hA5);
    wr(0, GPIO_REG_DO_SET, 32'h02);
    chk("do_set", 0, d_do[0], 32'hA7);
    wr(0, GPIO_REG_DO_CLR, 32'h80);
    chk("do_clr", 0, d_do[0], 32'h27);
    rd(0, GPIO_REG_DO_SET, 32'h27, "set_rd");

    // rise latency on bit0
    pad0 = 8'h00;
    repeat (4) tick();
    wr(0, GPIO_REG_RISE_EN, 32'h01);
    pad0 = 8'h01;
    repeat (3) tick();
    chk("rise_irq_t3", 0, {31'b0, irq0}, 32'h0);
    tick();
    chk("rise_irq_t4", 0, {31'b0, irq0}, 32'h1);
    rd(0, GPIO_REG_STATUS, 32'h01, "rise_st");
    rd(0, GPIO_REG_DATA_IN, 32'h01, "rise_din");
    pad0 = 8'h00;
    repeat (5) tick();
    rd(0, GPIO_REG_STATUS, 32'h01, "nofall_st");

    // W1C colliding with a fresh edge
    pad0 = 8'h01;
    repeat (2) tick();
    rv[0] = 1'b1; rwr[0] = 1'b1;
    ra[0] = GPIO_REG_STATUS; rdat[0] = 32'h01;
    tick();
    rv[0] = 1'b0; rwr[0] = 1'b0;
    chk("coll_irq", 0, {31'b0, irq0}, 32'h1);
    tick();
    chk("coll_irq2", 0, {31'b0, irq0}, 32'h1);
    rd(0, GPIO_REG_STATUS, 32'h01, "coll_st");
    wr(0, GPIO_REG_STATUS, 32'h01);
    chk("clr_irq_t1", 0, {31'b0, irq0}, 32'h1);
    tick();
    chk("clr_irq_t2", 0, {31'b0, irq0}, 32'h0);
    rd(0, GPIO_REG_STATUS, 32'h0, "clr_st");

    // 32-pin instance: full width, fall on bit31
    wr(1, GPIO_REG_OE, 32'hFFFF_FFFF);
    chk("oe32", 1, d_oe[1], 32'hFFFF_FFFF);
    rd(1, GPIO_REG_OE, 32'hFFFF_FFFF, "oe32_rd");
    pad1 = 32'h8000_0000;
    repeat (6) tick();
    wr(1, GPIO_REG_FALL_EN, 32'h8000_0000);
    pad1 = 32'h0;
    repeat (4) tick();
    chk("fall_irq_t4", 1, {31'b0, irq1}, 32'h0);
    tick();
    chk("fall_irq_t5", 1, {31'b0, irq1}, 32'h1);
    rd(1, GPIO_REG_STATUS, 32'h8000_0000, "fall_st");

    // back-to-back write/read, upper bits dropped
    wr(0, GPIO_REG_DATA_OUT, 32'hFFFF_FF3C);
    rd(0, GPIO_REG_DATA_OUT, 32'h3C, "b2b_do");
    wr(0, GPIO_REG_DATA_IN, 32'h0);
    rd(0, GPIO_REG_DATA_IN, 32'h01, "ro_din");

    // reset with a read in flight
    rv[0] = 1'b1; rwr[0] = 1'b0;
    ra[0] = GPIO_REG_DATA_OUT;
    reset = 1'b1;
    tick();
    rv[0] = 1'b0;
    chk("rst_rsp", 0, {31'b0, d_rv[0]}, 32'h0);
    chk("rst_do2", 0, d_do[0], 32'h0);
    chk("rst_oe2", 1, d_oe[1], 32'h0);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    rd(0, GPIO_REG_DATA_OUT, 32'h0, "post_rst_do");
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
